demux_scan: RTL and testbench
=============================

// Module: demux_scan
// PURPOSE
//  Downstream consumer of the free-running clock counter: derives a scan strobe
//  from one tap bit of the counter value and steps a one-hot demux select over
//  N_CH channels. Inserts a blanking gap between channels and presents the
//  latched data word of the active channel. Drives the multiplexed LED/digit
//  outputs of the demux demo.
// PARAMETERS
//  CNT_WIDTH  32  width of the incoming counter value
//  TAP_BIT    15  counter bit whose rising edge is the scan strobe (< CNT_WIDTH)
//  N_CH       4   number of demux channels (2..16)
//  CH_W       2   width of ch_idx; 2**CH_W >= N_CH
//  DW         8   data width per channel
//  BLANK_CYC  4   clk cycles with all selects off between channels (>= 1)
// PORTS
//  clk          in   1            system clock, all logic on posedge
//  neg_reset    in   1            synchronous, active-low reset
//  cnt_in       in   CNT_WIDTH    counter value from the clock counter
//  data_in      in   N_CH*DW      channel data, channel k = data_in[k*DW +: DW]
//  sel_out      out  N_CH         one-hot channel select, all-zero when blanked
//  data_out     out  DW           data of active channel, 0 when blanked
//  ch_idx       out  CH_W         index of current/next channel
//  frame_start  out  1            1-cycle pulse when channel 0 is driven
// BEHAVIOUR
//  - Reset (neg_reset==0 at posedge): sel_out=0, data_out=0, ch_idx=0,
//    frame_start=0, state=IDLE, tap_prev and armed cleared. Applies mid-scan too.
//  - cnt_in content is ignored while in reset (counter drives ~cnt then).
//  - Edge detect: tap_prev <= cnt_in[TAP_BIT] every cycle. First cycle after
//    reset release only loads tap_prev and sets armed; no strobe that cycle.
//    strobe = armed & cnt_in[TAP_BIT] & ~tap_prev.
//  - FSM states: IDLE, BLANK, DRIVE.
//    IDLE : on strobe -> BLANK, blank_cnt=BLANK_CYC-1, ch_idx stays 0.
//    BLANK: sel_out=0, data_out=0; blank_cnt decrements each cycle; at 0 ->
//           DRIVE next cycle with sel_out=1<<ch_idx,
//           data_out=data_in slice of ch_idx (sampled on that transition edge),
//           frame_start=1 for that one cycle iff ch_idx==0.
//    DRIVE: outputs held stable (data_in changes not visible). On strobe ->
//           BLANK, ch_idx <= (ch_idx==N_CH-1) ? 0 : ch_idx+1.
//  - Strobe during BLANK is dropped (no queueing, no skipped channel).
//  - Latency: strobe cycle -> sel_out asserted exactly BLANK_CYC+1 cycles later.
//  - ch_idx wraps N_CH-1 -> 0; never takes values >= N_CH.
//  - sel_out is always zero or exactly one-hot; never two bits in one cycle.
//  - Tap bit wrap (1->0 with counter overflow) is not a strobe; only 0->1.
// TESTING
//  1 Reset: hold neg_reset=0 5 cycles with cnt_in=all-ones -> sel_out=0,
//    data_out=0, ch_idx=0, frame_start=0; release, no strobe on first cycle.
//  2 Scan: TAP_BIT=2, cnt_in incrementing each clk, data_in=0x44_33_22_11 ->
//    sel_out 0001/0010/0100/1000 with data_out 11/22/33/44, frame_start only on 0001.
//  3 Timing: single 0->1 tap edge at cycle T -> sel_out nonzero first at
//    T+BLANK_CYC+1 (T+5 default), 0 for cycles T+1..T+BLANK_CYC.
//  4 Wrap: N_CH=3, 7 strobes -> ch_idx sequence 0,1,2,0,1,2,0; never 3.
//  5 Strobe in BLANK: second edge 2 cycles after first -> ignored, ch_idx
//    advances by one only.
//  6 Reset mid-DRIVE on channel 2 -> next cycle all outputs 0, ch_idx=0; scan
//    restarts at channel 0 with frame_start pulse.

Source files
------------

// File: rtl/demux_scan.sv
// ---------------------------------------------------------------------------
// demux_scan
//
// Consumes the free-running clock counter and steps a one-hot demux select
// across N_CH channels. A scan strobe is produced on every 0->1 transition
// of counter bit TAP_BIT. Every strobe starts a blanking gap of BLANK_CYC
// cycles with all selects off. The next channel is then driven with its data
// word, which is latched at the moment the channel turns on.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   neg_reset    synchronous, active-low reset
//   cnt_in       counter value from the clock counter (only TAP_BIT is used)
//   data_in      channel data, channel k = data_in[k*DW +: DW]
//   sel_out      one-hot channel select, all-zero while blanked or idle
//   data_out     latched data of the active channel, zero while blanked
//   ch_idx       index of the channel being driven or about to be driven
//   frame_start  one-cycle pulse when channel 0 is switched on
// ---------------------------------------------------------------------------
module demux_scan #(
    parameter int CNT_WIDTH = 32,
    parameter int TAP_BIT   = 15,
    parameter int N_CH      = 4,
    parameter int CH_W      = 2,
    parameter int DW        = 8,
    parameter int BLANK_CYC = 4
) (
    input  logic                 clk,
    input  logic                 neg_reset,
    input  logic [CNT_WIDTH-1:0] cnt_in,
    input  logic [N_CH*DW-1:0]   data_in,
    output logic [N_CH-1:0]      sel_out,
    output logic [DW-1:0]        data_out,
    output logic [CH_W-1:0]      ch_idx,
    output logic                 frame_start
);

    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0]   BLANK_LOAD = BW'(BLANK_CYC - 1);
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t          state, state_next;
    logic [BW-1:0]   blank_cnt, blank_next;
    logic [CH_W-1:0] ch_next;
    logic [N_CH-1:0] sel_next, sel_dec;
    logic [DW-1:0]   data_next, data_sel;
    logic            fs_next;
    logic            tap_prev;
    logic            armed;
    logic            strobe;

    // Only the tap bit of the counter matters; the remaining bits are folded
    // into a deliberately unused net so the port can keep its full width.
    logic            unused_cnt_bits;
    assign unused_cnt_bits = ^cnt_in;

    // armed masks the first cycle after reset. Until then tap_prev holds the
    // reset value rather than a real sample, so a high tap bit would
    // otherwise look like a rising edge.
    assign strobe = armed & cnt_in[TAP_BIT] & ~tap_prev;

    // Decode the current channel index into a one-hot select and pick the
    // matching data slice. The loop keeps every index a constant.
    always_comb begin
        sel_dec  = '0;
        data_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_idx == CH_W'(k)) begin
                sel_dec[k] = 1'b1;
                data_sel   = data_in[k*DW +: DW];
            end
        end
    end

    // Next-state and output logic. All outputs are registered. DRIVE only
    // keeps what was latched when the channel turned on, so later changes
    // on data_in stay invisible until the next channel. Strobes that arrive
    // during BLANK are simply dropped.
    always_comb begin
        state_next = state;
        blank_next = blank_cnt;
        ch_next    = ch_idx;
        sel_next   = sel_out;
        data_next  = data_out;
        fs_next    = 1'b0;
        case (state)
            IDLE: begin
                sel_next  = '0;
                data_next = '0;
                if (strobe) begin
                    state_next = BLANK;
                    blank_next = BLANK_LOAD;
                end
            end
            BLANK: begin
                sel_next  = '0;
                data_next = '0;
                if (blank_cnt == '0) begin
                    state_next = DRIVE;
                    sel_next   = sel_dec;
                    data_next  = data_sel;
                    fs_next    = (ch_idx == '0);
                end else begin
                    blank_next = blank_cnt - 1'b1;
                end
            end
            DRIVE: begin
                if (strobe) begin
                    state_next = BLANK;
                    blank_next = BLANK_LOAD;
                    ch_next    = (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;
                    sel_next   = '0;
                    data_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
                data_next  = '0;
            end
        endcase
    end

    // State and output registers. Reset is synchronous and may hit at any
    // point of the scan. While reset is asserted the edge detector is cleared
    // and disarmed, because the counter drives garbage during that time.
    always_ff @(posedge clk) begin
        if (!neg_reset) begin
            state       <= IDLE;
            blank_cnt   <= '0;
            ch_idx      <= '0;
            sel_out     <= '0;
            data_out    <= '0;
            frame_start <= 1'b0;
            tap_prev    <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state       <= state_next;
            blank_cnt   <= blank_next;
            ch_idx      <= ch_next;
            sel_out     <= sel_next;
            data_out    <= data_next;
            frame_start <= fs_next;
            tap_prev    <= cnt_in[TAP_BIT];
            armed       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_scan.sv
// ---------------------------------------------------------------------------
// tb_demux_scan
//
// Drives two instances of demux_scan (4 channels and 3 channels, tap bit 2,
// blanking gap 4) from a shared counter/data stimulus. Both outputs are
// compared every cycle against a cycle-number based reference model. There
// is also a hand-derived vector table and a few directed sequences.
// ---------------------------------------------------------------------------
module tb_demux_scan;

    localparam int BLANK = 4;

    logic        clk;
    logic        neg_reset;
    logic [31:0] cnt_in;
    logic [31:0] data_in;

    logic [3:0]  sel4;
    logic [7:0]  data4;
    logic [1:0]  ch4;
    logic        fs4;
    logic [2:0]  sel3;
    logic [7:0]  data3;
    logic [1:0]  ch3;
    logic        fs3;

    int tests;
    int fails;
    int edge_no;

    // Reference model: a scan is described by the channel number, the edge
    // number at which that channel turns on, and the latched data word.
    typedef struct {
        bit         armed;
        bit         prev;
        bit         started;
        int         ch;
        int         dedge;
        logic [7:0] data;
    } model_t;

    model_t m4, m3;

    typedef struct {
        bit         rst_n;
        logic [31:0] cnt;
        logic [3:0] sel;
        logic [7:0] dout;
        logic [1:0] ch;
        bit         fs;
    } vec_t;

    vec_t vecs[20];

    demux_scan #(.CNT_WIDTH(32), .TAP_BIT(2), .N_CH(4), .CH_W(2), .DW(8), .BLANK_CYC(BLANK)) dut4 (
        .clk(clk), .neg_reset(neg_reset), .cnt_in(cnt_in), .data_in(data_in),
        .sel_out(sel4), .data_out(data4), .ch_idx(ch4), .frame_start(fs4)
    );

    demux_scan #(.CNT_WIDTH(32), .TAP_BIT(2), .N_CH(3), .CH_W(2), .DW(8), .BLANK_CYC(BLANK)) dut3 (
        .clk(clk), .neg_reset(neg_reset), .cnt_in(cnt_in), .data_in(data_in[23:0]),
        .sel_out(sel3), .data_out(data3), .ch_idx(ch3), .frame_start(fs3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock edge, which has index e.
    function automatic model_t modelStep(model_t m, int n, bit rst_n, bit tap,
                                         logic [31:0] din, int e);
        bit strobe;
        if (!rst_n) begin
            m.armed = 0; m.prev = 0; m.started = 0;
            m.ch = 0; m.dedge = 0; m.data = '0;
            return m;
        end
        strobe = m.armed && tap && !m.prev;
        if (!m.started) begin
            if (strobe) begin
                m.started = 1;
                m.ch      = 0;
                m.dedge   = e + BLANK;
            end
        end else if (e == m.dedge) begin
            m.data = din[m.ch*8 +: 8];
        end else if (e > m.dedge && strobe) begin
            m.ch    = (m.ch + 1) % n;
            m.dedge = e + BLANK;
        end
        m.prev  = tap;
        m.armed = 1;
        return m;
    endfunction

    task automatic checkOutput(input string name,
                               input logic [15:0] gs, input logic [7:0] gd,
                               input logic [3:0] gc, input logic gf,
                               input logic [15:0] es, input logic [7:0] ed,
                               input logic [3:0] ec, input logic ef);
        tests++;
        if (gs !== es || gd !== ed || gc !== ec || gf !== ef) begin
            fails++;
            $display("[TB] FAIL %s @edge %0d: got sel=%0h data=%0h ch=%0d fs=%0b, expected sel=%0h data=%0h ch=%0d fs=%0b",
                     name, edge_no, gs, gd, gc, gf, es, ed, ec, ef);
        end
    endtask

    task automatic checkModel(input string name, input model_t m, input int e,
                              input logic [15:0] gs, input logic [7:0] gd,
                              input logic [3:0] gc, input logic gf);
        logic [15:0] es;
        logic [7:0]  ed;
        logic        ef;
        es = '0; ed = '0; ef = 1'b0;
        if (m.started && e >= m.dedge) begin
            es = 16'd1 << m.ch;
            ed = m.data;
            ef = (e == m.dedge) && (m.ch == 0);
        end
        checkOutput(name, gs, gd, gc, gf, es, ed, 4'(m.ch), ef);
    endtask

    // Apply one cycle of inputs, clock it, and compare both instances with
    // the model slightly after the edge.
    task automatic applyStimulus(input bit r, input logic [31:0] c, input logic [31:0] d);
        int e;
        neg_reset = r;
        cnt_in    = c;
        data_in   = d;
        @(posedge clk);
        e  = edge_no;
        m4 = modelStep(m4, 4, r, c[2], d, e);
        m3 = modelStep(m3, 3, r, c[2], d, e);
        #1;
        checkModel("model4", m4, e, 16'(sel4), data4, 4'(ch4), fs4);
        checkModel("model3", m3, e, 16'(sel3), data3, 4'(ch3), fs3);
        edge_no++;
    endtask

    initial begin
        logic [31:0] cnt;
        int          q3[$];
        logic [3:0]  qs[$];
        logic [7:0]  qd[$];
        logic        qf[$];
        bit          was3, was4, found;
        int          exp_ch[7];
        logic [3:0]  exp_sel[4];
        logic [7:0]  exp_dat[4];

        tests = 0; fails = 0; edge_no = 0;
        m4 = '{default: 0};
        m3 = '{default: 0};
        neg_reset = 1'b0; cnt_in = '1; data_in = 32'h4433_2211;

        // Hand-derived vectors: reset, first-cycle arming, strobe-to-drive
        // latency, and a strobe dropped during blanking.
        for (int i = 0; i < 5; i++) vecs[i] = '{0, 32'hFFFF_FFFF, 4'h0, 8'h00, 2'd0, 0};
        vecs[5]  = '{1, 32'hFFFF_FFFF, 4'h0, 8'h00, 2'd0, 0};
        vecs[6]  = '{1, 32'd0, 4'h0, 8'h00, 2'd0, 0};
        vecs[7]  = '{1, 32'd4, 4'h0, 8'h00, 2'd0, 0};
        vecs[8]  = '{1, 32'd4, 4'h0, 8'h00, 2'd0, 0};
        vecs[9]  = '{1, 32'd4, 4'h0, 8'h00, 2'd0, 0};
        vecs[10] = '{1, 32'd0, 4'h0, 8'h00, 2'd0, 0};
        vecs[11] = '{1, 32'd0, 4'h1, 8'h11, 2'd0, 1};
        vecs[12] = '{1, 32'd0, 4'h1, 8'h11, 2'd0, 0};
        vecs[13] = '{1, 32'd4, 4'h0, 8'h00, 2'd1, 0};
        vecs[14] = '{1, 32'd0, 4'h0, 8'h00, 2'd1, 0};
        vecs[15] = '{1, 32'd4, 4'h0, 8'h00, 2'd1, 0};
        vecs[16] = '{1, 32'd4, 4'h0, 8'h00, 2'd1, 0};
        vecs[17] = '{1, 32'd4, 4'h2, 8'h22, 2'd1, 0};
        vecs[18] = '{1, 32'd0, 4'h2, 8'h22, 2'd1, 0};
        vecs[19] = '{1, 32'd4, 4'h0, 8'h00, 2'd2, 0};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].cnt, 32'h4433_2211);
            checkOutput($sformatf("vec%0d", i), 16'(sel4), data4, 4'(ch4), fs4,
                        16'(vecs[i].sel), vecs[i].dout, 4'(vecs[i].ch), vecs[i].fs);
        end

        // Incrementing counter scan from a fresh reset. Record what each
        // instance shows when a channel turns on.
        applyStimulus(0, '1, 32'h4433_2211);
        applyStimulus(0, '1, 32'h4433_2211);
        cnt = 0; was3 = 0; was4 = 0;
        for (int i = 0; i < 90; i++) begin
            applyStimulus(1, cnt, 32'h4433_2211);
            cnt++;
            if (sel3 != 0 && !was3) q3.push_back(int'(ch3));
            if (sel4 != 0 && !was4) begin
                qs.push_back(sel4); qd.push_back(data4); qf.push_back(fs4);
            end
            was3 = (sel3 != 0);
            was4 = (sel4 != 0);
        end

        exp_ch  = '{0, 1, 2, 0, 1, 2, 0};
        exp_sel = '{4'h1, 4'h2, 4'h4, 4'h8};
        exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        tests++;
        if (q3.size() < 7 || qs.size() < 4) begin
            fails++;
            $display("[TB] FAIL scan_count: got %0d/%0d channel starts, expected at least 7/4", q3.size(), qs.size());
        end else begin
            for (int i = 0; i < 7; i++)
                checkOutput($sformatf("wrap%0d", i), 16'd0, 8'd0, 4'(q3[i]), 1'b0,
                            16'd0, 8'd0, 4'(exp_ch[i]), 1'b0);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("scan%0d", i), 16'(qs[i]), qd[i], 4'd0, qf[i],
                            16'(exp_sel[i]), exp_dat[i], 4'd0, (i == 0));
        end

        // Reset while channel 2 is driven, then the scan restarts at channel 0.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            applyStimulus(1, cnt, 32'h4433_2211);
            cnt++;
            if (sel4 == 4'b0100) found = 1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL reach_ch2: got no channel 2 drive within bound, expected one");
        end
        applyStimulus(0, ~cnt, 32'h4433_2211);
        checkOutput("mid_reset", 16'(sel4), data4, 4'(ch4), fs4, 16'd0, 8'd0, 4'd0, 1'b0);
        cnt = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1, cnt, 32'h4433_2211);
            cnt++;
            if (sel4 != 0) found = 1;
        end
        checkOutput("restart", 16'(sel4), data4, 4'(ch4), fs4, 16'd1, 8'h11, 4'd0, 1'b1);

        // Random counter taps, random data and occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) != 0, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
